// File: rtl/note_lane_scroller_if.sv
// Pattern RAM read bus for the note lane scroller.
//   ram_addr : read address, driven by the scroller (master)
//   ram_q    : read data, valid RAM_LAT cycles after ram_addr changes (slave)
interface note_lane_scroller_if #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 16
);
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_q;

    modport master (output ram_addr, input  ram_q);
    modport slave  (input  ram_addr, output ram_q);
endinterface

// File: rtl/note_lane_scroller.sv
// N-track note scroller. Streams per-track note words from a read-only
// pattern RAM into per-track staging registers and shifts them through a
// visible lane one step per game tick. Bit 0 of each track's lane is the
// hit window.
// Ports:
//   CLK, RESET_N : clock, asynchronous active-low reset
//   tick         : one-cycle game-step strobe
//   run          : 1 = advance on tick, 0 = paused
//   restart      : synchronous restart strobe (wins over tick)
//   ram          : pattern RAM read bus (master side)
//   lane         : lane bits, track t = lane[t*LANE_DEPTH +: LANE_DEPTH]
//   hit          : hit[t] = lane bit 0 of track t
//   load_pulse   : one cycle when staging reloads from prefetch
//   song_done    : level, song fully drained
//   tick_miss    : sticky, tick arrived while the RAM path was not ready
module note_lane_scroller #(
    parameter int unsigned NUM_TRACKS = 4,
    parameter int unsigned CHUNK      = 4,
    parameter int unsigned LANE_DEPTH = 8,
    parameter int unsigned ADDR_W     = 7,
    parameter int unsigned SONG_LEN   = 128,
    parameter int unsigned RAM_LAT    = 2,
    parameter int unsigned LOOP       = 0
) (
    input  logic                             CLK,
    input  logic                             RESET_N,
    input  logic                             tick,
    input  logic                             run,
    input  logic                             restart,
    note_lane_scroller_if.master             ram,
    output logic [NUM_TRACKS*LANE_DEPTH-1:0] lane,
    output logic [NUM_TRACKS-1:0]            hit,
    output logic                             load_pulse,
    output logic                             song_done,
    output logic                             tick_miss
);

    localparam int unsigned PH_W = (CHUNK > 1) ? $clog2(CHUNK) : 1;
    localparam int unsigned DR_W = $clog2(CHUNK + LANE_DEPTH + 1);
    localparam int unsigned WT_W = (RAM_LAT > 0) ? $clog2(RAM_LAT + 1) : 1;
    localparam int unsigned ST_W = NUM_TRACKS * CHUNK;
    localparam int unsigned LN_W = NUM_TRACKS * LANE_DEPTH;

    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(CHUNK - 1);
    localparam logic [DR_W-1:0]   DR_LAST   = DR_W'(CHUNK + LANE_DEPTH - 1);
    localparam logic [WT_W-1:0]   WT_LAST   = WT_W'(RAM_LAT);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SONG_LEN - 1);

    typedef enum logic [2:0] {
        S_PRIME,
        S_REFILL,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [LN_W-1:0]   lane_q, lane_d;
    logic [ST_W-1:0]   stg_q, stg_d;
    logic [ST_W-1:0]   pre_q, pre_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [WT_W-1:0]   wait_q, wait_d;
    logic [DR_W-1:0]   drain_q, drain_d;
    logic              past_q, past_d;    // ram_addr has moved beyond the last song word
    logic              lp_q, lp_d;
    logic              done_q, done_d;
    logic              miss_q, miss_d;

    logic step, wait_hit, load_now, last_addr, drain_end;

    assign step      = tick && run;
    assign wait_hit  = (wait_q == WT_LAST);
    assign load_now  = (phase_q == PH_LAST);
    assign last_addr = (addr_q == ADDR_LAST);
    assign drain_end = (drain_q == DR_LAST);

    // Each track's staging bit 0 enters the top of its lane.
    function automatic logic [LN_W-1:0] shift_lane(input logic [LN_W-1:0] l,
                                                   input logic [ST_W-1:0] s);
        logic [LN_W-1:0] r;
        r = '0;
        for (int unsigned t = 0; t < NUM_TRACKS; t++) begin
            r[t*LANE_DEPTH +: LANE_DEPTH] = {s[t*CHUNK], l[t*LANE_DEPTH+1 +: LANE_DEPTH-1]};
        end
        return r;
    endfunction

    function automatic logic [ST_W-1:0] shift_stg(input logic [ST_W-1:0] s);
        logic [ST_W-1:0] r;
        r = '0;
        for (int unsigned t = 0; t < NUM_TRACKS; t++) begin
            r[t*CHUNK +: CHUNK] = s[t*CHUNK +: CHUNK] >> 1;
        end
        return r;
    endfunction

    // State register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state_q <= S_PRIME;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (restart) begin
            state_d = S_PRIME;
        end else begin
            case (state_q)
                S_PRIME:  if (wait_hit) state_d = S_REFILL;
                S_REFILL: if (wait_hit) state_d = S_RUN;
                S_RUN: begin
                    if (step && load_now) begin
                        state_d = ((LOOP == 0) && past_q) ? S_DRAIN : S_REFILL;
                    end
                end
                S_DRAIN:  if (step && drain_end) state_d = S_DONE;
                S_DONE:   state_d = S_DONE;
                default:  state_d = S_PRIME;
            endcase
        end
    end

    // Datapath / registered-output next values
    always_comb begin
        lane_d  = lane_q;
        stg_d   = stg_q;
        pre_d   = pre_q;
        addr_d  = addr_q;
        phase_d = phase_q;
        wait_d  = wait_q;
        drain_d = drain_q;
        past_d  = past_q;
        lp_d    = 1'b0;
        done_d  = done_q;
        miss_d  = miss_q;

        if (restart) begin
            lane_d  = '0;
            stg_d   = '0;
            pre_d   = '0;
            addr_d  = '0;
            phase_d = '0;
            wait_d  = '0;
            drain_d = '0;
            past_d  = 1'b0;
            done_d  = 1'b0;
            miss_d  = 1'b0;
        end else begin
            case (state_q)
                S_PRIME: begin
                    if (step) miss_d = 1'b1;
                    if (wait_hit) begin
                        stg_d  = ram.ram_q;
                        addr_d = ADDR_W'(1);
                        wait_d = '0;
                    end else begin
                        wait_d = wait_q + WT_W'(1);
                    end
                end
                S_REFILL: begin
                    if (step) miss_d = 1'b1;
                    if (wait_hit) begin
                        pre_d  = past_q ? '0 : ram.ram_q;
                        wait_d = '0;
                    end else begin
                        wait_d = wait_q + WT_W'(1);
                    end
                end
                S_RUN: begin
                    if (step) begin
                        lane_d  = shift_lane(lane_q, stg_q);
                        stg_d   = shift_stg(stg_q);
                        phase_d = phase_q + PH_W'(1);
                        if (load_now) begin
                            // The shifted-out bit above still enters the lane;
                            // the whole staging word is then replaced.
                            phase_d = '0;
                            stg_d   = pre_q;
                            lp_d    = 1'b1;
                            if ((LOOP == 0) && past_q) begin
                                // Word SONG_LEN-1 has just been consumed.
                                pre_d   = '0;
                                drain_d = '0;
                            end else begin
                                wait_d = '0;
                                if (last_addr) begin
                                    addr_d = (LOOP != 0) ? '0 : addr_q + ADDR_W'(1);
                                    past_d = (LOOP == 0);
                                end else begin
                                    addr_d = addr_q + ADDR_W'(1);
                                end
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (step) begin
                        lane_d  = shift_lane(lane_q, stg_q);
                        stg_d   = shift_stg(stg_q);
                        drain_d = drain_q + DR_W'(1);
                        if (drain_end) begin
                            lane_d = '0;
                            stg_d  = '0;
                            done_d = 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    lane_d = '0;
                    stg_d  = '0;
                    done_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            lane_q  <= '0;
            stg_q   <= '0;
            pre_q   <= '0;
            addr_q  <= '0;
            phase_q <= '0;
            wait_q  <= '0;
            drain_q <= '0;
            past_q  <= 1'b0;
            lp_q    <= 1'b0;
            done_q  <= 1'b0;
            miss_q  <= 1'b0;
        end else begin
            lane_q  <= lane_d;
            stg_q   <= stg_d;
            pre_q   <= pre_d;
            addr_q  <= addr_d;
            phase_q <= phase_d;
            wait_q  <= wait_d;
            drain_q <= drain_d;
            past_q  <= past_d;
            lp_q    <= lp_d;
            done_q  <= done_d;
            miss_q  <= miss_d;
        end
    end

    always_comb begin
        hit = '0;
        for (int unsigned t = 0; t < NUM_TRACKS; t++) begin
            hit[t] = lane_q[t*LANE_DEPTH];
        end
    end

    assign ram.ram_addr = addr_q;
    assign lane         = lane_q;
    assign load_pulse   = lp_q;
    assign song_done    = done_q;
    assign tick_miss    = miss_q;

endmodule
